// File: rtl/hyperbus_trans_arbiter.sv
// Round-robin sharing of one HyperBus PHY transaction/TX/RX channel set among NR_REQ requesters.
// Latency: grant and descriptor registered one cycle after a request is seen in IDLE; data beats pass combinationally.
// Backpressure: trans/tx/rx ready-valid pass straight through to the granted requester; others see ready/valid low.
module hyperbus_trans_arbiter #(
    parameter int NR_REQ      = 2,
    parameter int NR_CS       = 2,
    parameter int BURST_WIDTH = 12
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,

    input  logic [NR_REQ-1:0]             req_valid_i,
    output logic [NR_REQ-1:0]             req_ready_o,
    output logic [NR_REQ-1:0]             req_error_o,
    input  logic [NR_REQ*32-1:0]          req_address_i,
    input  logic [NR_REQ*NR_CS-1:0]       req_cs_i,
    input  logic [NR_REQ-1:0]             req_write_i,
    input  logic [NR_REQ-1:0]             req_burst_type_i,
    input  logic [NR_REQ-1:0]             req_address_space_i,
    input  logic [NR_REQ*BURST_WIDTH-1:0] req_burst_i,

    input  logic [NR_REQ-1:0]             req_tx_valid_i,
    output logic [NR_REQ-1:0]             req_tx_ready_o,
    input  logic [NR_REQ*16-1:0]          req_tx_data_i,
    input  logic [NR_REQ*2-1:0]           req_tx_strb_i,

    output logic [NR_REQ-1:0]             req_rx_valid_o,
    input  logic [NR_REQ-1:0]             req_rx_ready_i,
    output logic [15:0]                   req_rx_data_o,
    output logic                          req_rx_last_o,

    output logic                          trans_valid_o,
    input  logic                          trans_ready_i,
    input  logic                          trans_error_i,
    output logic [31:0]                   trans_address_o,
    output logic [NR_CS-1:0]              trans_cs_o,
    output logic                          trans_write_o,
    output logic [BURST_WIDTH-1:0]        trans_burst_o,
    output logic                          trans_burst_type_o,
    output logic                          trans_address_space_o,

    output logic                          tx_valid_o,
    input  logic                          tx_ready_i,
    output logic [15:0]                   tx_data_o,
    output logic [1:0]                    tx_strb_o,

    input  logic                          rx_valid_i,
    output logic                          rx_ready_o,
    input  logic [15:0]                   rx_data_i,
    input  logic                          rx_last_i
);

    localparam int GW = $clog2(NR_REQ);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ISSUE  = 2'd1;
    localparam logic [1:0] ST_DATA   = 2'd2;
    localparam logic [1:0] ST_REJECT = 2'd3;

    typedef struct packed {
        logic [31:0]            address;
        logic [NR_CS-1:0]       cs;
        logic                   write;
        logic [BURST_WIDTH-1:0] burst;
        logic                   burst_type;
        logic                   address_space;
    } desc_t;

    desc_t       req_desc  [NR_REQ];
    logic [15:0] tx_data_a [NR_REQ];
    logic [1:0]  tx_strb_a [NR_REQ];

    for (genvar k = 0; k < NR_REQ; k++) begin : g_unpack
        assign req_desc[k] = '{
            address:       req_address_i[k*32 +: 32],
            cs:            req_cs_i[k*NR_CS +: NR_CS],
            write:         req_write_i[k],
            burst:         req_burst_i[k*BURST_WIDTH +: BURST_WIDTH],
            burst_type:    req_burst_type_i[k],
            address_space: req_address_space_i[k]
        };
        assign tx_data_a[k] = req_tx_data_i[k*16 +: 16];
        assign tx_strb_a[k] = req_tx_strb_i[k*2 +: 2];
    end

    logic [1:0]             state_q;
    logic [GW-1:0]          grant_q;
    logic [GW-1:0]          last_grant_q;
    desc_t                  desc_q;
    logic [BURST_WIDTH-1:0] beat_cnt_q;

    logic [GW-1:0]          sel;
    logic                   sel_vld;
    logic [NR_REQ-1:0]      grant_oh;
    logic                   tx_hs;
    logic                   rx_hs;

    // Search upward from the requester after the last one granted, wrapping at NR_REQ.
    always_comb begin
        int cand;
        cand    = 0;
        sel     = '0;
        sel_vld = 1'b0;
        for (int k = 1; k <= NR_REQ; k++) begin
            cand = int'(last_grant_q) + k;
            if (cand >= NR_REQ) cand = cand - NR_REQ;
            if (!sel_vld && req_valid_i[GW'(cand)]) begin
                sel_vld = 1'b1;
                sel     = GW'(cand);
            end
        end
    end

    assign grant_oh = NR_REQ'(1) << grant_q;
    assign tx_hs    = (state_q == ST_DATA) && desc_q.write && req_tx_valid_i[grant_q] && tx_ready_i;
    assign rx_hs    = (state_q == ST_DATA) && !desc_q.write && rx_valid_i && req_rx_ready_i[grant_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(NR_REQ - 1);
            desc_q       <= '0;
            beat_cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (sel_vld) begin
                        grant_q <= sel;
                        desc_q  <= req_desc[sel];
                        state_q <= (req_desc[sel].burst == '0) ? ST_REJECT : ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (trans_ready_i) begin
                        last_grant_q <= grant_q;
                        if (trans_error_i) begin
                            state_q <= ST_IDLE;
                        end else begin
                            beat_cnt_q <= desc_q.burst;
                            state_q    <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (tx_hs) begin
                        beat_cnt_q <= beat_cnt_q - 1'b1;
                        if (beat_cnt_q == BURST_WIDTH'(1)) state_q <= ST_IDLE;
                    end
                    // Read length is owned by the PHY's last flag; the count only checks it.
                    if (rx_hs) begin
                        if (beat_cnt_q != '0) beat_cnt_q <= beat_cnt_q - 1'b1;
                        if (rx_last_i) state_q <= ST_IDLE;
                    end
                end
                default: begin
                    last_grant_q <= grant_q;
                    state_q      <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        req_ready_o    = '0;
        req_error_o    = '0;
        req_tx_ready_o = '0;
        req_rx_valid_o = '0;
        trans_valid_o  = 1'b0;
        tx_valid_o     = 1'b0;
        rx_ready_o     = 1'b0;
        case (state_q)
            ST_ISSUE: begin
                trans_valid_o = 1'b1;
                if (trans_ready_i) begin
                    req_ready_o = grant_oh;
                    if (trans_error_i) req_error_o = grant_oh;
                end
            end
            ST_DATA: begin
                if (desc_q.write) begin
                    tx_valid_o = req_tx_valid_i[grant_q];
                    if (tx_ready_i) req_tx_ready_o = grant_oh;
                end else begin
                    rx_ready_o = req_rx_ready_i[grant_q];
                    if (rx_valid_i) req_rx_valid_o = grant_oh;
                    if (rx_hs && ((rx_last_i && beat_cnt_q != BURST_WIDTH'(1)) || beat_cnt_q == '0))
                        req_error_o = grant_oh;
                end
            end
            ST_REJECT: begin
                req_ready_o = grant_oh;
                req_error_o = grant_oh;
            end
            default: ;
        endcase
    end

    assign trans_address_o       = desc_q.address;
    assign trans_cs_o            = desc_q.cs;
    assign trans_write_o         = desc_q.write;
    assign trans_burst_o         = desc_q.burst;
    assign trans_burst_type_o    = desc_q.burst_type;
    assign trans_address_space_o = desc_q.address_space;

    assign tx_data_o     = tx_data_a[grant_q];
    assign tx_strb_o     = tx_strb_a[grant_q];
    assign req_rx_data_o = rx_data_i;
    assign req_rx_last_o = rx_last_i;

endmodule

// File: tb/tb_hyperbus_trans_arbiter.sv
// Bench for hyperbus_trans_arbiter: directed vector table, hand sequences and a randomized round-robin model.
module tb_hyperbus_trans_arbiter;
    localparam int NR  = 2;
    localparam int NCS = 2;
    localparam int BW  = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_ni;
    logic [NR-1:0]       req_valid_i, req_ready_o, req_error_o;
    logic [NR*32-1:0]    req_address_i;
    logic [NR*NCS-1:0]   req_cs_i;
    logic [NR-1:0]       req_write_i, req_burst_type_i, req_address_space_i;
    logic [NR*BW-1:0]    req_burst_i;
    logic [NR-1:0]       req_tx_valid_i, req_tx_ready_o;
    logic [NR*16-1:0]    req_tx_data_i;
    logic [NR*2-1:0]     req_tx_strb_i;
    logic [NR-1:0]       req_rx_valid_o, req_rx_ready_i;
    logic [15:0]         req_rx_data_o;
    logic                req_rx_last_o;
    logic                trans_valid_o, trans_ready_i, trans_error_i;
    logic [31:0]         trans_address_o;
    logic [NCS-1:0]      trans_cs_o;
    logic                trans_write_o, trans_burst_type_o, trans_address_space_o;
    logic [BW-1:0]       trans_burst_o;
    logic                tx_valid_o, tx_ready_i;
    logic [15:0]         tx_data_o;
    logic [1:0]          tx_strb_o;
    logic                rx_valid_i, rx_ready_o, rx_last_i;
    logic [15:0]         rx_data_i;

    logic [31:0]  d_addr  [NR];
    logic [NCS-1:0] d_cs  [NR];
    logic         d_write [NR];
    logic [BW-1:0] d_burst[NR];
    logic         d_bt    [NR];
    logic         d_as    [NR];
    logic [15:0]  d_txd   [NR];
    logic [1:0]   d_strb  [NR];

    always_comb begin
        req_address_i = '0; req_cs_i = '0; req_write_i = '0; req_burst_i = '0;
        req_burst_type_i = '0; req_address_space_i = '0; req_tx_data_i = '0; req_tx_strb_i = '0;
        for (int k = 0; k < NR; k++) begin
            req_address_i[k*32 +: 32]  = d_addr[k];
            req_cs_i[k*NCS +: NCS]     = d_cs[k];
            req_write_i[k]             = d_write[k];
            req_burst_i[k*BW +: BW]    = d_burst[k];
            req_burst_type_i[k]        = d_bt[k];
            req_address_space_i[k]     = d_as[k];
            req_tx_data_i[k*16 +: 16]  = d_txd[k];
            req_tx_strb_i[k*2 +: 2]    = d_strb[k];
        end
    end

    hyperbus_trans_arbiter #(.NR_REQ(NR), .NR_CS(NCS), .BURST_WIDTH(BW)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_error_o(req_error_o),
        .req_address_i(req_address_i), .req_cs_i(req_cs_i), .req_write_i(req_write_i),
        .req_burst_type_i(req_burst_type_i), .req_address_space_i(req_address_space_i),
        .req_burst_i(req_burst_i),
        .req_tx_valid_i(req_tx_valid_i), .req_tx_ready_o(req_tx_ready_o),
        .req_tx_data_i(req_tx_data_i), .req_tx_strb_i(req_tx_strb_i),
        .req_rx_valid_o(req_rx_valid_o), .req_rx_ready_i(req_rx_ready_i),
        .req_rx_data_o(req_rx_data_o), .req_rx_last_o(req_rx_last_o),
        .trans_valid_o(trans_valid_o), .trans_ready_i(trans_ready_i), .trans_error_i(trans_error_i),
        .trans_address_o(trans_address_o), .trans_cs_o(trans_cs_o), .trans_write_o(trans_write_o),
        .trans_burst_o(trans_burst_o), .trans_burst_type_o(trans_burst_type_o),
        .trans_address_space_o(trans_address_space_o),
        .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i), .tx_data_o(tx_data_o), .tx_strb_o(tx_strb_o),
        .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o), .rx_data_i(rx_data_i), .rx_last_i(rx_last_i)
    );

    int tests  = 0;
    int failed = 0;
    int model_lg;

    typedef struct {
        logic [1:0] mask;
        logic       write;
        int         burst;
        logic       perr;
        int         delay;
        int         last_beat;
        logic       stalls;
        int         exp_g;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [NR-1:0] oh(input int g);
        return NR'(1) << g;
    endfunction

    // Round-robin rule: first pending requester strictly after the last granted one, wrapping.
    function automatic int rr(input int lg, input logic [NR-1:0] m);
        for (int k = 1; k <= NR; k++)
            if (m[(lg + k) % NR]) return (lg + k) % NR;
        return 0;
    endfunction

    task automatic clear_data();
        req_tx_valid_i = '0; tx_ready_i = 1'b0; rx_valid_i = 1'b0; rx_last_i = 1'b0;
        req_rx_ready_i = '0; rx_data_i = '0;
    endtask

    task automatic idle_check();
        @(negedge clk);
        chk("idle_trans_valid", trans_valid_o, 0);
        chk("idle_req_ready", req_ready_o, 0);
        chk("idle_req_error", req_error_o, 0);
        chk("idle_tx_valid", tx_valid_o, 0);
        chk("idle_req_tx_ready", req_tx_ready_o, 0);
        chk("idle_rx_ready", rx_ready_o, 0);
        chk("idle_req_rx_valid", req_rx_valid_o, 0);
        clear_data();
    endtask

    task automatic chk_desc(input int g);
        chk("desc_valid", trans_valid_o, 1);
        chk("desc_addr", trans_address_o, d_addr[g]);
        chk("desc_burst", trans_burst_o, d_burst[g]);
        chk("desc_write", trans_write_o, d_write[g]);
        chk("desc_cs", trans_cs_o, d_cs[g]);
        chk("desc_attr", {trans_burst_type_o, trans_address_space_o}, {d_bt[g], d_as[g]});
    endtask

    task automatic txn(input int g, input bit perr, input int delay, input int last_beat, input bit stalls);
        int b;
        b = int'(d_burst[g]);
        idle_check();
        @(posedge clk); #1;
        if (b == 0) begin
            @(negedge clk);
            chk("rej_ready", req_ready_o, oh(g));
            chk("rej_error", req_error_o, oh(g));
            chk("rej_trans_valid", trans_valid_o, 0);
            @(posedge clk); #1;
            model_lg = g;
            return;
        end
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            chk_desc(g);
            chk("hold_req_ready", req_ready_o, 0);
            @(posedge clk); #1;
        end
        trans_ready_i = 1'b1; trans_error_i = perr;
        @(negedge clk);
        chk_desc(g);
        chk("accept_ready", req_ready_o, oh(g));
        chk("accept_error", req_error_o, perr ? oh(g) : '0);
        @(posedge clk); #1;
        trans_ready_i = 1'b0; trans_error_i = 1'b0;
        model_lg = g;
        if (perr) begin
            // Present data on every channel; the following idle check must see none of it routed.
            req_tx_valid_i = '1; tx_ready_i = 1'b1; rx_valid_i = 1'b1; req_rx_ready_i = '1;
            return;
        end
        if (d_write[g]) begin
            for (int k = 0; k < b; k++) begin
                if (stalls && $urandom_range(0, 2) == 0) begin
                    req_tx_valid_i[g] = 1'b1; tx_ready_i = 1'b0;
                    @(negedge clk);
                    chk("tx_stall_valid", tx_valid_o, 1);
                    chk("tx_stall_ready", req_tx_ready_o, 0);
                    @(posedge clk); #1;
                end
                d_txd[g] = 16'($urandom); d_strb[g] = 2'($urandom);
                req_tx_valid_i[g] = 1'b1; tx_ready_i = 1'b1;
                @(negedge clk);
                chk("tx_valid", tx_valid_o, 1);
                chk("tx_data", {tx_strb_o, tx_data_o}, {d_strb[g], d_txd[g]});
                chk("tx_req_ready", req_tx_ready_o, oh(g));
                chk("tx_no_rx", req_rx_valid_o, 0);
                @(posedge clk); #1;
            end
        end else begin
            for (int i = 1; i <= last_beat; i++) begin
                rx_data_i = 16'($urandom); rx_last_i = (i == last_beat); rx_valid_i = 1'b1;
                if (stalls) begin
                    req_rx_ready_i[g] = 1'b0;
                    @(negedge clk);
                    chk("rx_stall_valid", req_rx_valid_o, oh(g));
                    chk("rx_stall_ready", rx_ready_o, 0);
                    chk("rx_stall_error", req_error_o, 0);
                    @(posedge clk); #1;
                end
                req_rx_ready_i[g] = 1'b1;
                @(negedge clk);
                chk("rx_valid", req_rx_valid_o, oh(g));
                chk("rx_ready", rx_ready_o, 1);
                chk("rx_data", {req_rx_last_o, req_rx_data_o}, {rx_last_i, rx_data_i});
                chk("rx_error", req_error_o, ((i > b) || (i == last_beat && i != b)) ? oh(g) : '0);
                chk("rx_no_tx", req_tx_ready_o, 0);
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic do_reset();
        rst_ni = 1'b0; req_valid_i = '0; trans_ready_i = 1'b0; trans_error_i = 1'b0;
        clear_data();
        repeat (2) @(posedge clk);
        #1 rst_ni = 1'b1;
        model_lg = NR - 1;
    endtask

    task automatic set_desc(input int k, input logic [31:0] a, input logic w, input int b);
        d_addr[k] = a; d_write[k] = w; d_burst[k] = BW'(b);
        d_cs[k] = NCS'(k + 1); d_bt[k] = k[0]; d_as[k] = ~k[0];
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int k = 0; k < NR; k++) begin
            set_desc(k, 32'h0, 1'b0, 0); d_txd[k] = '0; d_strb[k] = '0;
        end
        tbl[0]  = '{2'b01, 1'b1, 4, 1'b0, 3, 0, 1'b0, 0};
        tbl[1]  = '{2'b11, 1'b1, 1, 1'b0, 0, 0, 1'b0, 1};
        tbl[2]  = '{2'b11, 1'b1, 1, 1'b0, 0, 0, 1'b0, 0};
        tbl[3]  = '{2'b11, 1'b1, 1, 1'b0, 0, 0, 1'b0, 1};
        tbl[4]  = '{2'b11, 1'b1, 1, 1'b0, 1, 0, 1'b0, 0};
        tbl[5]  = '{2'b10, 1'b0, 3, 1'b0, 0, 3, 1'b1, 1};
        tbl[6]  = '{2'b11, 1'b1, 2, 1'b1, 1, 0, 1'b0, 0};
        tbl[7]  = '{2'b11, 1'b1, 2, 1'b0, 0, 0, 1'b0, 1};
        tbl[8]  = '{2'b01, 1'b0, 4, 1'b0, 0, 2, 1'b0, 0};
        tbl[9]  = '{2'b10, 1'b0, 2, 1'b0, 0, 3, 1'b0, 1};
        tbl[10] = '{2'b11, 1'b1, 0, 1'b0, 0, 0, 1'b0, 0};
        tbl[11] = '{2'b11, 1'b1, 3, 1'b0, 0, 0, 1'b1, 1};

        do_reset();
        @(negedge clk);
        chk("reset_desc", {trans_address_o, trans_burst_o, trans_write_o}, 0);
        chk("reset_outputs", {trans_valid_o, req_ready_o, req_error_o, tx_valid_o, rx_ready_o}, 0);
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) begin
            for (int k = 0; k < NR; k++)
                set_desc(k, 32'h100 + 32'(i) * 32'h40 + 32'(k) * 32'h1000, tbl[i].write, tbl[i].burst);
            req_valid_i = tbl[i].mask;
            txn(tbl[i].exp_g, tbl[i].perr, tbl[i].delay, tbl[i].last_beat, tbl[i].stalls);
        end

        // After reset: req1 alone, then both pending, must grant 1 then 0.
        do_reset();
        for (int k = 0; k < NR; k++) set_desc(k, 32'h2000 + 32'(k), 1'b1, 1);
        req_valid_i = 2'b10;
        txn(1, 1'b0, 0, 0, 1'b0);
        req_valid_i = 2'b11;
        txn(0, 1'b0, 0, 0, 1'b0);

        // Asynchronous reset two beats into an 8-beat write from req0.
        do_reset();
        set_desc(0, 32'h8000, 1'b1, 8);
        req_valid_i = 2'b01;
        idle_check();
        @(posedge clk); #1;
        trans_ready_i = 1'b1;
        @(negedge clk);
        chk("rst_accept", req_ready_o, 2'b01);
        @(posedge clk); #1;
        trans_ready_i = 1'b0; req_valid_i = '0;
        for (int k = 0; k < 2; k++) begin
            req_tx_valid_i[0] = 1'b1; tx_ready_i = 1'b1; d_txd[0] = 16'($urandom);
            @(posedge clk); #1;
        end
        chk("rst_pre_tx_valid", tx_valid_o, 1);
        rst_ni = 1'b0;
        #1;
        chk("rst_tx_valid", tx_valid_o, 0);
        chk("rst_tx_ready", req_tx_ready_o, 0);
        chk("rst_ready_error", {req_ready_o, req_error_o, trans_valid_o, rx_ready_o}, 0);
        chk("rst_desc", {trans_address_o, trans_burst_o}, 0);
        clear_data();
        repeat (2) @(posedge clk);
        #1 rst_ni = 1'b1;
        model_lg = NR - 1;
        for (int k = 0; k < NR; k++) set_desc(k, 32'h3000 + 32'(k), 1'b1, 1);
        req_valid_i = 2'b11;
        txn(0, 1'b0, 0, 0, 1'b0);

        for (int it = 0; it < 40; it++) begin
            int g, b, lb, r;
            for (int k = 0; k < NR; k++) begin
                set_desc(k, $urandom, 1'($urandom), $urandom_range(0, 4));
                d_cs[k] = NCS'($urandom);
            end
            req_valid_i = 2'($urandom_range(1, 3));
            g  = rr(model_lg, req_valid_i);
            b  = int'(d_burst[g]);
            r  = $urandom_range(0, 3);
            lb = (r == 0 && b > 1) ? b - 1 : (r == 1) ? b + 1 : b;
            txn(g, ($urandom_range(0, 7) == 0), $urandom_range(0, 2), lb, 1'b1);
        end

        req_valid_i = '0;
        idle_check();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
